// File: rtl/fpu_unpack_stage_if.sv
// Handshake and payload bundle for the FPU unpack stage: raw operand in, unpacked operand out.
interface fpu_unpack_stage_if #(
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_num;
  logic [23:0]      out_sig;
  logic [9:0]       out_exp;
  logic [5:0]       out_class;
  logic [TAG_W-1:0] out_tag;
  logic             clr_flags;
  logic [3:0]       flags;

  modport master (
    output in_valid, in_data, in_tag, out_ready, clr_flags,
    input  in_ready, out_valid, out_num, out_sig, out_exp, out_class, out_tag, flags
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready, clr_flags,
    output in_ready, out_valid, out_num, out_sig, out_exp, out_class, out_tag, flags
  );
endinterface

// File: rtl/fpu_unpack_stage.sv
// Two-stage elastic front end of the FPU: registers raw IEEE-754 singles, classifies them
// and widens significand/exponent, with sticky exception-class flags.
module fpu_unpack_stage #(
  parameter int unsigned TAG_W = 4
) (
  input logic            clk,
  input logic            rst,
  fpu_unpack_stage_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIG_W  = 24;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned CLS_W  = 6;
  localparam int unsigned FLG_W  = 4;

  localparam logic [EXP_W-1:0] EXP_DENORM = EXP_W'(-126);
  localparam logic [EXP_W-1:0] EXP_SPECIAL = EXP_W'(128);
  localparam logic [EXP_W-1:0] EXP_BIAS   = EXP_W'(127);

  // One-hot class bits {snan, qnan, inf, norm, sub, zero}
  localparam int unsigned C_ZERO = 0;
  localparam int unsigned C_SUB  = 1;
  localparam int unsigned C_NORM = 2;
  localparam int unsigned C_INF  = 3;
  localparam int unsigned C_QNAN = 4;
  localparam int unsigned C_SNAN = 5;

  logic              s1_v;
  logic [DATA_W-1:0] s1_data;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_v;
  logic [DATA_W-1:0] s2_num;
  logic [SIG_W-1:0]  s2_sig;
  logic [EXP_W-1:0]  s2_exp;
  logic [CLS_W-1:0]  s2_class;
  logic [TAG_W-1:0]  s2_tag;
  logic [FLG_W-1:0]  flags_q;

  logic              s2_load_c;
  logic              s1_load_c;
  logic              out_hs_c;
  logic [CLS_W-1:0]  cls_c;
  logic [SIG_W-1:0]  sig_c;
  logic [EXP_W-1:0]  exp_c;
  logic [FLG_W-1:0]  flags_d_c;

  logic [7:0]  s1_bexp;
  logic [22:0] s1_frac;

  assign s1_bexp = s1_data[30:23];
  assign s1_frac = s1_data[22:0];

  // Elastic advance: downstream ready ripples combinationally back to in_ready
  assign s2_load_c = !s2_v || bus.out_ready;
  assign s1_load_c = !s1_v || s2_load_c;
  assign out_hs_c  = s2_v && bus.out_ready;

  always_comb begin
    cls_c = '0;
    sig_c = '0;
    exp_c = EXP_DENORM;
    if (s1_bexp == 8'd0) begin
      sig_c = {1'b0, s1_frac};
      if (s1_frac == 23'd0) cls_c[C_ZERO] = 1'b1;
      else                  cls_c[C_SUB]  = 1'b1;
    end else if (s1_bexp == 8'hFF) begin
      sig_c = {1'b1, s1_frac};
      exp_c = EXP_SPECIAL;
      if (s1_frac == 23'd0)  cls_c[C_INF]  = 1'b1;
      else if (s1_frac[22])  cls_c[C_QNAN] = 1'b1;
      else                   cls_c[C_SNAN] = 1'b1;
    end else begin
      sig_c = {1'b1, s1_frac};
      exp_c = EXP_W'(s1_bexp) - EXP_BIAS;
      cls_c[C_NORM] = 1'b1;
    end
  end

  // Set beats clear when both happen in the same cycle
  always_comb begin
    flags_d_c = bus.clr_flags ? '0 : flags_q;
    if (out_hs_c) begin
      flags_d_c = flags_d_c | {s2_class[C_SNAN], s2_class[C_QNAN], s2_class[C_INF], s2_class[C_SUB]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_tag  <= '0;
    end else if (s1_load_c) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data <= bus.in_data;
        s1_tag  <= bus.in_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v     <= 1'b0;
      s2_num   <= '0;
      s2_sig   <= '0;
      s2_exp   <= '0;
      s2_class <= '0;
      s2_tag   <= '0;
    end else if (s2_load_c) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_num   <= s1_data;
        s2_sig   <= sig_c;
        s2_exp   <= exp_c;
        s2_class <= cls_c;
        s2_tag   <= s1_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d_c;
  end

  assign bus.in_ready  = s1_load_c;
  assign bus.out_valid = s2_v;
  assign bus.out_num   = s2_num;
  assign bus.out_sig   = s2_sig;
  assign bus.out_exp   = s2_exp;
  assign bus.out_class = s2_class;
  assign bus.out_tag   = s2_tag;
  assign bus.flags     = flags_q;
endmodule
